// File: rtl/umio_pkt_fifo.sv
// umio_pkt_fifo
//   Frame-aware synchronous FIFO with a first-word-fall-through read port.
//   Written words stay invisible to the reader until their frame is closed
//   with wr_last. A frame closed with wr_drop, or one that overflows, is
//   rolled back by returning the write pointer to the last commit point.
//
// Optional feature macro: UMIO_PKT_FIFO_STATS_EN
//   When defined, adds the saturating statistics outputs drop_cnt and ovf_cnt.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   wr_data/wr_en         write word and strobe
//   wr_last/wr_drop       end of frame / discard the frame on its last beat
//   full, almost_full     used == DEPTH / used >= AF_LEVEL (used includes
//                         uncommitted words)
//   ovf                   one-cycle pulse when a frame is lost to overflow
//   rd_data/rd_last       head word and its end-of-frame flag
//   rd_valid/rd_en        head word present / pop the head word
//   frm_cnt               committed frames not yet fully popped
//   drop_cnt, ovf_cnt     (stats build only) discarded / overflowed frames
module umio_pkt_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2048,
    parameter int AF_LEVEL = 1536,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             wr_last,
    input  logic             wr_drop,
    output logic             full,
    output logic             almost_full,
    output logic             ovf,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic             rd_valid,
    input  logic             rd_en,
`ifdef UMIO_PKT_FIFO_STATS_EN
    output logic [15:0]      drop_cnt,
    output logic [15:0]      ovf_cnt,
`endif
    output logic [AW:0]      frm_cnt
);

    logic [WIDTH:0] mem [DEPTH];

    logic [AW:0]    wr_ptr;
    logic [AW:0]    cmt_ptr;
    logic [AW:0]    rd_ptr;     // advances on pop; defines occupancy
    logic [AW:0]    fch_ptr;    // next committed word to fetch from RAM
    logic [AW:0]    used;
    logic           bad;
    logic           s1_vld;
    logic [WIDTH:0] s1_q;

    logic wr_ok, commit, drop, overflow, pop, s1_move, fetch;

    assign used        = wr_ptr - rd_ptr;
    assign full        = (used == (AW+1)'(DEPTH));
    assign almost_full = (used >= (AW+1)'(AF_LEVEL));

    assign wr_ok    = wr_en & ~full & ~bad;
    assign commit   = wr_ok & wr_last & ~wr_drop;
    assign drop     = wr_ok & wr_last & wr_drop;
    assign overflow = wr_en & full & ~bad;

    // Prefetch pipeline: RAM read register (s1) feeding the output register.
    // A fetch is only issued when s1 will be free at the next edge, so the
    // registered RAM output never needs to be held. Prefetched words still
    // count as used, so the writer can never overwrite them, and the fetch
    // address never reaches the word being written this cycle.
    assign pop     = rd_en & rd_valid;
    assign s1_move = s1_vld & (~rd_valid | pop);
    assign fetch   = (fch_ptr != cmt_ptr) & (~s1_vld | s1_move);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
        if (fetch)
            s1_q <= mem[fch_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            cmt_ptr  <= '0;
            rd_ptr   <= '0;
            fch_ptr  <= '0;
            bad      <= 1'b0;
            ovf      <= 1'b0;
            s1_vld   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            frm_cnt  <= '0;
        end else begin
            // Write side: rollback to the commit point wins over advancing
            if (drop || overflow)
                wr_ptr <= cmt_ptr;
            else if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;

            if (commit)
                cmt_ptr <= wr_ptr + 1'b1;

            // An overflowing last beat ends the frame itself, so bad stays clear
            if (overflow)
                bad <= ~wr_last;
            else if (bad && wr_en && wr_last)
                bad <= 1'b0;

            ovf <= overflow;

            // Read side
            if (fetch)
                fch_ptr <= fch_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            if (fetch)
                s1_vld <= 1'b1;
            else if (s1_move)
                s1_vld <= 1'b0;

            if (s1_move) begin
                rd_valid <= 1'b1;
                rd_data  <= s1_q[WIDTH-1:0];
                rd_last  <= s1_q[WIDTH];
            end else if (pop) begin
                rd_valid <= 1'b0;
            end

            case ({commit, pop & rd_last})
                2'b10:   frm_cnt <= frm_cnt + 1'b1;
                2'b01:   frm_cnt <= frm_cnt - 1'b1;
                default: frm_cnt <= frm_cnt;
            endcase
        end
    end

`ifdef UMIO_PKT_FIFO_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
            if (overflow && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_umio_pkt_fifo.sv
// tb_umio_pkt_fifo
//   Self-checking bench for umio_pkt_fifo with a 16-word instance. A table
//   of per-cycle vectors covers the basic frame, hand-written sequences
//   cover drop, overflow, simultaneous commit/pop, streaming wrap and reset.
//   Popped words are compared against a queue of expected {last,data}.
module tb_umio_pkt_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en, wr_last, wr_drop;
    logic             full, almost_full, ovf;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last, rd_valid, rd_en;
    logic [AW:0]      frm_cnt;
`ifdef UMIO_PKT_FIFO_STATS_EN
    logic [15:0]      drop_cnt, ovf_cnt;
`endif

    umio_pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_en(wr_en), .wr_last(wr_last), .wr_drop(wr_drop),
        .full(full), .almost_full(almost_full), .ovf(ovf),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_en(rd_en),
`ifdef UMIO_PKT_FIFO_STATS_EN
        .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt),
`endif
        .frm_cnt(frm_cnt)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;
    int ovf_seen = 0;
    bit sb_on = 1'b0;
    logic [WIDTH:0] exp_q [$];

    typedef struct {
        logic [7:0] wd;
        logic       we, wl, wdrop, re;
        logic       exp_rv;
        logic [7:0] exp_rd;
        logic       exp_rl;
        logic [4:0] exp_frm;
        logic       exp_full;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every popped word with the oldest expected one
    always @(negedge clk) begin
        if (ovf) ovf_seen++;
        if (sb_on && rd_valid && rd_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {23'd0, rd_last, rd_data}, 32'hFFFF_FFFF);
            end else begin
                check("pop_word", {23'd0, rd_last, rd_data}, {23'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic write_frame(input int len, input logic [7:0] base,
                               input logic drop, input logic ok);
        for (int i = 0; i < len; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            wr_last = (i == len - 1);
            wr_drop = drop && (i == len - 1);
            if (ok) exp_q.push_back({wr_last, wr_data});
            tick();
        end
        wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rd_valid && n < 50) begin
            tick();
            n++;
        end
        check(name, {31'd0, rd_valid}, 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        rd_en = 1'b1;
        while ((exp_q.size() != 0 || rd_valid) && n < 200) begin
            tick();
            n++;
        end
        rd_en = 1'b0;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; wr_data = '0; wr_en = 0; wr_last = 0; wr_drop = 0; rd_en = 0;
        tick(); tick();
        check("rst_rd_valid", {31'd0, rd_valid}, 0);
        check("rst_rd_data", {24'd0, rd_data}, 0);
        check("rst_flags", {28'd0, full, almost_full, ovf, rd_last}, 0);
        check("rst_frm_cnt", {27'd0, frm_cnt}, 0);
        rst = 1'b0;
        tick();

        // Basic frame 11,22,33: visible two edges after the commit edge
        //        wd     we wl dr re  rv  rd     rl frm full
        vecs[0] = '{8'h11, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0};
        vecs[1] = '{8'h22, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0};
        vecs[2] = '{8'h33, 1, 1, 0, 0, 0, 8'h00, 0, 1, 0};
        vecs[3] = '{8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0};
        vecs[4] = '{8'h00, 0, 0, 0, 0, 1, 8'h11, 0, 1, 0};
        vecs[5] = '{8'h00, 0, 0, 0, 1, 1, 8'h22, 0, 1, 0};
        vecs[6] = '{8'h00, 0, 0, 0, 1, 1, 8'h33, 1, 1, 0};
        vecs[7] = '{8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            wr_data = vecs[i].wd; wr_en = vecs[i].we; wr_last = vecs[i].wl;
            wr_drop = vecs[i].wdrop; rd_en = vecs[i].re;
            tick();
            check($sformatf("vec%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_rv});
            if (vecs[i].exp_rv) begin
                check($sformatf("vec%0d_rd_data", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_rd});
                check($sformatf("vec%0d_rd_last", i), {31'd0, rd_last}, {31'd0, vecs[i].exp_rl});
            end
            check($sformatf("vec%0d_frm_cnt", i), {27'd0, frm_cnt}, {27'd0, vecs[i].exp_frm});
            check($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
        end
        wr_en = 0; wr_last = 0; rd_en = 0;
        sb_on = 1'b1;

        // Dropped frame leaves no trace; next frame reads out
        write_frame(4, 8'h40, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("drop_no_valid", {31'd0, rd_valid}, 0);
            tick();
        end
        check("drop_frm_cnt", {27'd0, frm_cnt}, 0);
        check("drop_used_zero", {30'd0, full, almost_full}, 0);
        check("drop_no_ovf", ovf_seen, 0);
`ifdef UMIO_PKT_FIFO_STATS_EN
        check("drop_cnt_one", {16'd0, drop_cnt}, 1);
`endif
        write_frame(1, 8'hAA, 1'b0, 1'b1);
        wait_valid("aa_valid");
        drain("aa_drain");

        // Overflow: 20-word frame into a 16-word FIFO with no reads
        ovf_seen = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i); wr_last = (i == 19); wr_drop = 1'b0;
            tick();
            if (i == 10) check("ovf_af_below", {31'd0, almost_full}, 0);
            if (i == 11) check("ovf_af_at", {31'd0, almost_full}, 1);
            if (i == 14) check("ovf_not_full_yet", {31'd0, full}, 0);
            if (i == 15) check("ovf_full", {31'd0, full}, 1);
            if (i == 16) begin
                check("ovf_pulse", {31'd0, ovf}, 1);
                check("ovf_full_rollback", {31'd0, full}, 0);
            end
            if (i == 17) check("ovf_pulse_end", {31'd0, ovf}, 0);
        end
        wr_en = 0; wr_last = 0;
        repeat (4) tick();
        check("ovf_one_pulse", ovf_seen, 1);
        check("ovf_frm_cnt", {27'd0, frm_cnt}, 0);
        check("ovf_no_valid", {31'd0, rd_valid}, 0);
`ifdef UMIO_PKT_FIFO_STATS_EN
        check("ovf_cnt_one", {16'd0, ovf_cnt}, 1);
`endif
        // FIFO must accept a normal frame after the bad frame
        write_frame(2, 8'h70, 1'b0, 1'b1);
        wait_valid("post_ovf_valid");
        drain("post_ovf_drain");

        // Commit frame B on the same edge the last word of frame A is popped
        write_frame(2, 8'hA0, 1'b0, 1'b1);
        wait_valid("a_valid");
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("a_last_head", {23'd0, rd_last, rd_data}, {23'd0, 1'b1, 8'hA1});
        check("a_frm_cnt", {27'd0, frm_cnt}, 1);
        rd_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'hB0; wr_last = 1'b1;
        exp_q.push_back({1'b1, 8'hB0});
        tick();
        wr_en = 0; wr_last = 0; rd_en = 0;
        check("ab_frm_cnt", {27'd0, frm_cnt}, 1);
        wait_valid("b_valid");
        drain("b_drain");
        check("ab_frm_zero", {27'd0, frm_cnt}, 0);

        // Stream 3*DEPTH one-word frames; reads start once almost_full is up
        ovf_seen = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (i == 14) rd_en = 1'b1;
            write_frame(1, 8'(8'h80 + i), 1'b0, 1'b1);
            if (i == 10) check("strm_af_below", {31'd0, almost_full}, 0);
            if (i == 11) check("strm_af_at", {31'd0, almost_full}, 1);
            if (i == 30) check("strm_not_full", {31'd0, full}, 0);
        end
        drain("strm_drain");
        check("strm_af_low", {31'd0, almost_full}, 0);
        check("strm_no_ovf", ovf_seen, 0);
        check("strm_frm_zero", {27'd0, frm_cnt}, 0);

        // Reset mid-read and mid-frame
        write_frame(2, 8'hC0, 1'b0, 1'b1);
        wait_valid("c_valid");
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b1; wr_data = 8'hD0; wr_last = 1'b0;
        tick();
        wr_data = 8'hD1;
        rst = 1'b1;
        tick();
        wr_en = 1'b0;
        exp_q.delete();
        check("rst_mid_valid", {31'd0, rd_valid}, 0);
        check("rst_mid_data", {24'd0, rd_data}, 0);
        check("rst_mid_flags", {28'd0, full, almost_full, ovf, rd_last}, 0);
        check("rst_mid_frm", {27'd0, frm_cnt}, 0);
        rst = 1'b0;
        tick();
        write_frame(1, 8'h5A, 1'b0, 1'b1);
        wait_valid("5a_valid");
        check("5a_head", {23'd0, rd_last, rd_data}, {23'd0, 1'b1, 8'h5A});
        drain("5a_drain");
`ifdef UMIO_PKT_FIFO_STATS_EN
        check("rst_drop_cnt", {16'd0, drop_cnt}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
